// File: rtl/store_mem_unit.sv
// Store execution unit: turns an accepted store into one or two word-aligned
// write beats on the data-memory port, with byte enables and lane-aligned data.
module store_mem_unit #(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        store_valid,
    output logic        store_ready,
    input  logic [2:0]  store_control,
    input  logic [31:0] store_addr,
    input  logic [31:0] store_data,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    output logic        store_done,
    output logic        store_fault
);
    // Store control encodings shared with the store decoder.
    localparam logic [2:0] STR_NOP = 3'b000;
    localparam logic [2:0] SB      = 3'b001;
    localparam logic [2:0] SH      = 3'b010;
    localparam logic [2:0] SW      = 3'b011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_e;

    state_e      state_q;
    logic        mem_req_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [3:0]  mem_be_q;
    logic        store_done_q;
    logic        store_fault_q;
    logic [3:0]  b1_be_q;
    logic [31:0] b1_wdata_q;

    logic [3:0]  mask;
    logic [7:0]  be8;
    logic [63:0] w64;
    logic        need_b1;
    logic        accept;

    always_comb begin
        mask = 4'b0000;
        case (store_control)
            SB:      mask = 4'b0001;
            SH:      mask = 4'b0011;
            SW:      mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
    end

    assign be8     = {4'b0000, mask} << store_addr[1:0];
    assign w64     = {32'h0000_0000, store_data} << {store_addr[1:0], 3'b000};
    assign need_b1 = |be8[7:4];

    // A store transfers at a rising edge where store_valid and store_ready are
    // both high; a memory beat transfers at a rising edge where mem_req and
    // mem_ack are both high, and mem_addr/mem_wdata/mem_be hold until then.
    assign store_ready = (state_q == IDLE) && !reset;
    assign accept      = store_valid && store_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= 32'h0;
            mem_wdata_q   <= 32'h0;
            mem_be_q      <= 4'b0000;
            store_done_q  <= 1'b0;
            store_fault_q <= 1'b0;
            b1_be_q       <= 4'b0000;
            b1_wdata_q    <= 32'h0;
        end else begin
            store_done_q  <= 1'b0;
            store_fault_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (mask == 4'b0000) begin
                            store_done_q <= 1'b1;
                        end else if (need_b1 && !ALLOW_MISALIGNED) begin
                            store_done_q  <= 1'b1;
                            store_fault_q <= 1'b1;
                        end else begin
                            state_q     <= BEAT0;
                            mem_req_q   <= 1'b1;
                            mem_addr_q  <= {store_addr[31:2], 2'b00};
                            mem_be_q    <= be8[3:0];
                            mem_wdata_q <= w64[31:0];
                            b1_be_q     <= be8[7:4];
                            b1_wdata_q  <= w64[63:32];
                        end
                    end
                end
                BEAT0: begin
                    if (mem_ack) begin
                        if (b1_be_q != 4'b0000) begin
                            // Address wraps past the top of memory to word 0.
                            state_q     <= BEAT1;
                            mem_addr_q  <= mem_addr_q + 32'd4;
                            mem_be_q    <= b1_be_q;
                            mem_wdata_q <= b1_wdata_q;
                        end else begin
                            state_q      <= IDLE;
                            mem_req_q    <= 1'b0;
                            mem_be_q     <= 4'b0000;
                            store_done_q <= 1'b1;
                        end
                    end
                end
                BEAT1: begin
                    if (mem_ack) begin
                        state_q      <= IDLE;
                        mem_req_q    <= 1'b0;
                        mem_be_q     <= 4'b0000;
                        store_done_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_be      = mem_be_q;
    assign store_done  = store_done_q;
    assign store_fault = store_fault_q;
endmodule

// File: tb/tb_store_mem_unit.sv
// Bench for store_mem_unit: instance 0 splits misaligned stores, instance 1
// rejects them; both are checked against a byte-level model of the store rules.
module tb_store_mem_unit;
    localparam logic [2:0] STR_NOP = 3'b000;
    localparam logic [2:0] SB      = 3'b001;
    localparam logic [2:0] SH      = 3'b010;
    localparam logic [2:0] SW      = 3'b011;

    logic        clk;
    logic        reset;
    logic [1:0]  s_valid;
    logic [1:0]  s_ready;
    logic [2:0]  s_ctl[2];
    logic [31:0] s_addr[2];
    logic [31:0] s_data[2];
    logic [1:0]  m_req;
    logic [1:0]  m_ack;
    logic [31:0] m_addr[2];
    logic [31:0] m_wdata[2];
    logic [3:0]  m_be[2];
    logic [1:0]  s_done;
    logic [1:0]  s_fault;

    int tests;
    int fails;
    logic [67:0] exp_q[$];

    store_mem_unit #(.ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .reset(reset),
        .store_valid(s_valid[0]), .store_ready(s_ready[0]),
        .store_control(s_ctl[0]), .store_addr(s_addr[0]), .store_data(s_data[0]),
        .mem_req(m_req[0]), .mem_ack(m_ack[0]), .mem_addr(m_addr[0]),
        .mem_wdata(m_wdata[0]), .mem_be(m_be[0]),
        .store_done(s_done[0]), .store_fault(s_fault[0])
    );

    store_mem_unit #(.ALLOW_MISALIGNED(1'b0)) dut_nm (
        .clk(clk), .reset(reset),
        .store_valid(s_valid[1]), .store_ready(s_ready[1]),
        .store_control(s_ctl[1]), .store_addr(s_addr[1]), .store_data(s_data[1]),
        .mem_req(m_req[1]), .mem_ack(m_ack[1]), .mem_addr(m_addr[1]),
        .mem_wdata(m_wdata[1]), .mem_be(m_be[1]),
        .store_done(s_done[1]), .store_fault(s_fault[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: place each of the four data bytes at byte position off+i of a
    // two-word window; the low size bytes are enabled; word 1 is a beat only if enabled.
    task automatic model(input logic [2:0] ctl, input logic [31:0] addr,
                         input logic [31:0] data, input bit allow, output bit fault);
        logic [3:0]  wb[2];
        logic [31:0] wd[2];
        logic [31:0] w0;
        int n, off, p;
        exp_q.delete();
        fault = 1'b0;
        wb[0] = 4'b0; wb[1] = 4'b0; wd[0] = 32'h0; wd[1] = 32'h0;
        off = int'(addr[1:0]);
        n = (ctl == SB) ? 1 : (ctl == SH) ? 2 : (ctl == SW) ? 4 : 0;
        for (int i = 0; i < 4; i++) begin
            p = off + i;
            wd[p/4][8*(p%4) +: 8] = data[8*i +: 8];
            if (i < n) wb[p/4][p%4] = 1'b1;
        end
        w0 = {addr[31:2], 2'b00};
        if (n == 0) return;
        if (wb[1] != 4'b0 && !allow) begin
            fault = 1'b1;
            return;
        end
        exp_q.push_back({w0, wb[0], wd[0]});
        if (wb[1] != 4'b0) exp_q.push_back({w0 + 32'd4, wb[1], wd[1]});
    endtask

    // Called and returns at a falling edge; dly < 0 picks a random ack delay per beat.
    task automatic run_store(input int d, input logic [2:0] ctl, input logic [31:0] addr,
                             input logic [31:0] data, input int dly);
        bit          ef;
        logic [67:0] b;
        int          dl;
        model(ctl, addr, data, (d == 0), ef);
        s_ctl[d] = ctl; s_addr[d] = addr; s_data[d] = data; s_valid[d] = 1'b1;
        tests++;
        if (s_ready[d] !== 1'b1) begin
            fails++;
            $display("FAIL ready_before_accept d%0d: got %b want 1", d, s_ready[d]);
        end
        @(posedge clk); #1 s_valid[d] = 1'b0;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            tests++;
            if ({m_req[d], s_done[d], s_fault[d], s_ready[d]} !== {1'b0, 1'b1, ef, 1'b1}) begin
                fails++;
                $display("FAIL no_beat d%0d ctl=%0d addr=%h: got req/done/fault/ready=%b%b%b%b want 0%b%b1",
                         d, ctl, addr, m_req[d], s_done[d], s_fault[d], s_ready[d], 1'b1, ef);
            end
        end else begin
            b = '0;
            while (exp_q.size() > 0) begin
                b  = exp_q.pop_front();
                dl = (dly < 0) ? $urandom_range(0, 3) : dly;
                for (int k = 0; k <= dl; k++) begin
                    tests++;
                    if ({m_req[d], m_addr[d], m_be[d], m_wdata[d], s_done[d], s_ready[d]} !==
                        {1'b1, b, 1'b0, 1'b0}) begin
                        fails++;
                        $display("FAIL beat d%0d: got req=%b addr=%h be=%b wdata=%h done=%b ready=%b want req=1 addr=%h be=%b wdata=%h done=0 ready=0",
                                 d, m_req[d], m_addr[d], m_be[d], m_wdata[d], s_done[d], s_ready[d],
                                 b[67:36], b[35:32], b[31:0]);
                    end
                    s_valid[d] = 1'($urandom_range(0, 1));
                    s_ctl[d]   = 3'($urandom_range(0, 7));
                    s_addr[d]  = $urandom;
                    s_data[d]  = $urandom;
                    if (k == dl) m_ack[d] = 1'b1;
                    @(posedge clk); #1 m_ack[d] = 1'b0; s_valid[d] = 1'b0;
                    @(negedge clk);
                end
            end
            tests++;
            if ({m_req[d], m_be[d], s_done[d], s_fault[d], s_ready[d], m_addr[d], m_wdata[d]} !==
                {1'b0, 4'b0, 1'b1, 1'b0, 1'b1, b[67:36], b[31:0]}) begin
                fails++;
                $display("FAIL retire d%0d: got req=%b be=%b done=%b fault=%b ready=%b addr=%h wdata=%h want 0 0000 1 0 1 %h %h",
                         d, m_req[d], m_be[d], s_done[d], s_fault[d], s_ready[d], m_addr[d], m_wdata[d],
                         b[67:36], b[31:0]);
            end
        end
    endtask

    task automatic idle_cycle(input int d);
        @(posedge clk); @(negedge clk);
        tests++;
        if ({m_req[d], m_be[d], s_done[d], s_fault[d], s_ready[d]} !== {1'b0, 4'b0, 1'b0, 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL idle d%0d: got req=%b be=%b done=%b fault=%b ready=%b want 0 0000 0 0 1",
                     d, m_req[d], m_be[d], s_done[d], s_fault[d], s_ready[d]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            tests++;
            if ({m_req[d], m_addr[d], m_wdata[d], m_be[d], s_done[d], s_fault[d]} !== 71'b0) begin
                fails++;
                $display("FAIL reset_state d%0d: got req=%b addr=%h wdata=%h be=%b done=%b fault=%b want all 0",
                         d, m_req[d], m_addr[d], m_wdata[d], m_be[d], s_done[d], s_fault[d]);
            end
        end
        #1 reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            tests++;
            if (s_ready[d] !== 1'b1) begin
                fails++;
                $display("FAIL ready_after_reset d%0d: got %b want 1", d, s_ready[d]);
            end
        end
    endtask

    task automatic test_directed();
        run_store(0, SB, 32'h0000_1003, 32'h0000_00AB, 0);
        idle_cycle(0);
        run_store(0, SW, 32'h0000_2000, 32'hDEAD_BEEF, 3);
        run_store(0, SW, 32'h0000_2002, 32'h1122_3344, 0);
        run_store(0, SH, 32'hFFFF_FFFF, 32'h0000_BEEF, 1);
        run_store(0, STR_NOP, 32'h0000_4000, 32'h1234_5678, 0);
        idle_cycle(0);
        run_store(0, 3'b110, 32'h0000_4001, 32'h1234_5678, 0);
        idle_cycle(0);
        run_store(1, SH, 32'h0000_3003, 32'h0000_CAFE, 0);
        idle_cycle(1);
        run_store(1, STR_NOP, 32'h0000_3000, 32'h0, 0);
        idle_cycle(1);
        run_store(1, SW, 32'h0000_3004, 32'h5566_7788, 2);
        run_store(1, SH, 32'h0000_3002, 32'h0000_9ABC, 0);
        run_store(1, SW, 32'h0000_3001, 32'h0102_0304, 0);
        idle_cycle(1);
    endtask

    task automatic test_back_to_back();
        run_store(0, SW, 32'h0000_5001, 32'hA1A2_A3A4, 0);
        run_store(0, SB, 32'h0000_5005, 32'hB1B2_B3B4, 0);
        run_store(0, SH, 32'h0000_5007, 32'hC1C2_C3C4, 0);
        run_store(0, STR_NOP, 32'h0000_5008, 32'h0, 0);
        run_store(0, SW, 32'h0000_500C, 32'hD1D2_D3D4, 0);
        idle_cycle(0);
    endtask

    task automatic test_random();
        int          d, r;
        logic [2:0]  ctl;
        logic [31:0] addr;
        for (int i = 0; i < 160; i++) begin
            d = (i % 4 == 3) ? 1 : 0;
            r = $urandom_range(0, 9);
            ctl = (r < 3) ? SB : (r < 6) ? SH : (r < 9) ? SW : 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 7) == 0) addr[31:3] = '1;
            run_store(d, ctl, addr, $urandom, -1);
            if ($urandom_range(0, 2) == 0) idle_cycle(d);
        end
    endtask

    task automatic test_reset_mid_beat();
        s_ctl[0] = SW; s_addr[0] = 32'h0000_2002; s_data[0] = 32'h1122_3344; s_valid[0] = 1'b1;
        @(posedge clk); #1 s_valid[0] = 1'b0;
        @(negedge clk); m_ack[0] = 1'b1;
        @(posedge clk); #1 m_ack[0] = 1'b0;
        @(negedge clk);
        tests++;
        if ({m_req[0], m_addr[0], m_be[0]} !== {1'b1, 32'h0000_2004, 4'b0011}) begin
            fails++;
            $display("FAIL mid_beat1 setup: got req=%b addr=%h be=%b want 1 00002004 0011",
                     m_req[0], m_addr[0], m_be[0]);
        end
        reset = 1'b1;
        #1;
        tests++;
        if ({m_req[0], m_be[0], s_done[0]} !== 6'b0) begin
            fails++;
            $display("FAIL reset_drops_req: got req=%b be=%b done=%b want 0 0000 0", m_req[0], m_be[0], s_done[0]);
        end
        #2 reset = 1'b0;
        @(negedge clk);
        tests++;
        if ({s_ready[0], m_req[0], s_done[0]} !== 3'b100) begin
            fails++;
            $display("FAIL after_mid_reset: got ready=%b req=%b done=%b want 1 0 0", s_ready[0], m_req[0], s_done[0]);
        end
        run_store(0, SB, 32'h0000_6002, 32'h0000_0077, 0);
        idle_cycle(0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        s_valid = 2'b00;
        m_ack = 2'b00;
        for (int d = 0; d < 2; d++) begin
            s_ctl[d] = STR_NOP; s_addr[d] = 32'h0; s_data[d] = 32'h0;
        end
        test_reset();
        test_directed();
        test_back_to_back();
        test_random();
        test_reset_mid_beat();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
